// File: rtl/bus_drvr_fifo.sv
// Per-port bus driver buffering: a TX FIFO drained by the bus and an RX FIFO filled by the bus.
// Both are show-ahead circular buffers with sticky misuse flags and a synchronised reset release.

module bus_drvr_fifo_buf #(
    parameter int pckg_sz = 16,
    parameter int depth   = 8,
    parameter int cnt_w   = $clog2(depth) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_run,
    input  logic               i_wr,
    input  logic [pckg_sz-1:0] i_wdata,
    input  logic               i_rd,
    input  logic               i_clr,
    output logic               o_full,
    output logic [cnt_w-1:0]   o_count,
    output logic               o_valid,
    output logic [pckg_sz-1:0] o_rdata,
    output logic               o_err
);
    localparam int aw = $clog2(depth);

    logic [pckg_sz-1:0] r_mem [depth];
    logic [aw-1:0]      r_wr_ptr;
    logic [aw-1:0]      r_rd_ptr;
    logic [cnt_w-1:0]   r_count;
    logic               r_err;

    logic w_empty;
    logic w_full;
    logic w_rd_ok;
    logic w_wr_ok;
    logic w_err_now;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == cnt_w'(depth));

    // A write into a full FIFO is only accepted when the head leaves in the same cycle.
    assign w_rd_ok   = i_run & i_rd & ~w_empty;
    assign w_wr_ok   = i_run & i_wr & (~w_full | w_rd_ok);
    assign w_err_now = i_run & ((i_wr & w_full & ~i_rd) | (i_rd & w_empty));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_wr_ok) r_wr_ptr <= r_wr_ptr + aw'(1);
            if (w_rd_ok) r_rd_ptr <= r_rd_ptr + aw'(1);
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + cnt_w'(1);
                2'b01:   r_count <= r_count - cnt_w'(1);
                default: r_count <= r_count;
            endcase
            // A new error in the clearing cycle keeps the flag set.
            if (i_run) r_err <= (r_err & ~i_clr) | w_err_now;
        end
    end

    // NOTE: storage has no reset; its contents are masked by the empty check on the read port.
    always_ff @(posedge clk) begin
        if (w_wr_ok) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_full  = w_full;
    assign o_count = r_count;
    assign o_valid = ~w_empty;
    assign o_rdata = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_err   = r_err;
endmodule

module bus_drvr_fifo #(
    parameter int    pckg_sz = 16,
    parameter int    depth   = 8,
    localparam int   cnt_w   = $clog2(depth) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tx_wr,
    input  logic [pckg_sz-1:0] tx_data,
    output logic               tx_full,
    output logic [cnt_w-1:0]   tx_count,
    output logic               pndng,
    output logic [pckg_sz-1:0] D_pop,
    input  logic               pop,
    input  logic               push,
    input  logic [pckg_sz-1:0] D_push,
    input  logic               rx_rd,
    output logic [pckg_sz-1:0] rx_data,
    output logic               rx_valid,
    output logic [cnt_w-1:0]   rx_count,
    output logic               ovf_tx,
    output logic               ovf_rx,
    input  logic               clr_err
);
    logic [1:0] r_rst_sync;
    logic       w_run;

    // Reset asserts immediately; release is retimed through two flops before traffic is accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_rst_sync <= 2'b00;
        else        r_rst_sync <= {r_rst_sync[0], 1'b1};
    end

    assign w_run = r_rst_sync[1];

    bus_drvr_fifo_buf #(.pckg_sz(pckg_sz), .depth(depth), .cnt_w(cnt_w)) u_tx (
        .clk     (clk),
        .rst_n   (reset),
        .i_run   (w_run),
        .i_wr    (tx_wr),
        .i_wdata (tx_data),
        .i_rd    (pop),
        .i_clr   (clr_err),
        .o_full  (tx_full),
        .o_count (tx_count),
        .o_valid (pndng),
        .o_rdata (D_pop),
        .o_err   (ovf_tx)
    );

    logic w_rx_full_unused;

    bus_drvr_fifo_buf #(.pckg_sz(pckg_sz), .depth(depth), .cnt_w(cnt_w)) u_rx (
        .clk     (clk),
        .rst_n   (reset),
        .i_run   (w_run),
        .i_wr    (push),
        .i_wdata (D_push),
        .i_rd    (rx_rd),
        .i_clr   (clr_err),
        .o_full  (w_rx_full_unused),
        .o_count (rx_count),
        .o_valid (rx_valid),
        .o_rdata (rx_data),
        .o_err   (ovf_rx)
    );
endmodule

// File: tb/tb_bus_drvr_fifo.sv
// Bench for bus_drvr_fifo: reset-state vector table, directed corner sequences, and a
// randomized run checked against queue-based FIFO models.

module tb_bus_drvr_fifo;
    localparam int W = 16;
    localparam int D = 8;
    localparam int CW = $clog2(D) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          tx_wr = 1'b0;
    logic [W-1:0]  tx_data = '0;
    logic          tx_full;
    logic [CW-1:0] tx_count;
    logic          pndng;
    logic [W-1:0]  D_pop;
    logic          pop = 1'b0;
    logic          push = 1'b0;
    logic [W-1:0]  D_push = '0;
    logic          rx_rd = 1'b0;
    logic [W-1:0]  rx_data;
    logic          rx_valid;
    logic [CW-1:0] rx_count;
    logic          ovf_tx;
    logic          ovf_rx;
    logic          clr_err = 1'b0;

    bus_drvr_fifo #(.pckg_sz(W), .depth(D)) dut (
        .clk(clk), .reset(reset),
        .tx_wr(tx_wr), .tx_data(tx_data), .tx_full(tx_full), .tx_count(tx_count),
        .pndng(pndng), .D_pop(D_pop), .pop(pop),
        .push(push), .D_push(D_push), .rx_rd(rx_rd), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_count(rx_count),
        .ovf_tx(ovf_tx), .ovf_rx(ovf_rx), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // Reference model: plain queues plus sticky flags.
    logic [W-1:0] tx_q[$];
    logic [W-1:0] rx_q[$];
    bit m_ovt = 0;
    bit m_ovr = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic model_fifo(inout logic [W-1:0] q[$], inout bit flag,
                              input bit wr, input logic [W-1:0] d, input bit rd, input bit clr);
        bit err;
        bit rd_ok;
        bit wr_ok;
        err   = (wr && q.size() == D && !rd) || (rd && q.size() == 0);
        rd_ok = rd && q.size() > 0;
        wr_ok = wr && (q.size() < D || rd_ok);
        if (rd_ok) void'(q.pop_front());
        if (wr_ok) q.push_back(d);
        flag = clr ? err : (flag | err);
    endtask

    task automatic check_all(input string tag);
        check({tag, ".tx_count"}, 32'(tx_count), 32'(tx_q.size()));
        check({tag, ".tx_full"},  32'(tx_full),  32'(tx_q.size() == D));
        check({tag, ".pndng"},    32'(pndng),    32'(tx_q.size() != 0));
        check({tag, ".D_pop"},    32'(D_pop),    32'(tx_q.size() != 0 ? tx_q[0] : '0));
        check({tag, ".rx_count"}, 32'(rx_count), 32'(rx_q.size()));
        check({tag, ".rx_valid"}, 32'(rx_valid), 32'(rx_q.size() != 0));
        check({tag, ".rx_data"},  32'(rx_data),  32'(rx_q.size() != 0 ? rx_q[0] : '0));
        check({tag, ".ovf_tx"},   32'(ovf_tx),   32'(m_ovt));
        check({tag, ".ovf_rx"},   32'(ovf_rx),   32'(m_ovr));
    endtask

    // One clock with the given inputs; model advances at the edge, outputs checked 1 ns later.
    task automatic cyc(input string tag, input bit wr, input logic [W-1:0] d, input bit pp,
                       input bit ps, input logic [W-1:0] dp, input bit rr, input bit clr);
        tx_wr = wr; tx_data = d; pop = pp; push = ps; D_push = dp; rx_rd = rr; clr_err = clr;
        @(posedge clk);
        model_fifo(tx_q, m_ovt, wr, d, pp, clr);
        model_fifo(rx_q, m_ovr, ps, dp, rr, clr);
        #1;
        tx_wr = 0; pop = 0; push = 0; rx_rd = 0; clr_err = 0;
        check_all(tag);
    endtask

    task automatic release_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic          tx_wr;
        logic [W-1:0]  tx_data;
        logic          pop;
        logic          push;
        logic [W-1:0]  d_push;
        logic          rx_rd;
        logic          clr;
        logic [CW-1:0] e_txc;
        logic [W-1:0]  e_dpop;
        logic          e_ovt;
        logic [CW-1:0] e_rxc;
        logic [W-1:0]  e_rxd;
        logic          e_ovr;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int max_rx;
        int seen_dead;
        int beef_pos;
        logic [W-1:0] got;

        tbl[0] = '{1, 16'h0101, 0, 0, 16'h0000, 0, 0, 1, 16'h0101, 0, 0, 16'h0000, 0};
        tbl[1] = '{1, 16'h0102, 0, 1, 16'h1111, 0, 0, 2, 16'h0101, 0, 1, 16'h1111, 0};
        tbl[2] = '{0, 16'h0000, 1, 1, 16'h2222, 0, 0, 1, 16'h0102, 0, 2, 16'h1111, 0};
        tbl[3] = '{1, 16'h0103, 1, 0, 16'h0000, 1, 0, 1, 16'h0103, 0, 1, 16'h2222, 0};
        tbl[4] = '{0, 16'h0000, 1, 0, 16'h0000, 1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0};
        tbl[5] = '{0, 16'h0000, 1, 0, 16'h0000, 0, 0, 0, 16'h0000, 1, 0, 16'h0000, 0};
        tbl[6] = '{1, 16'h0104, 1, 1, 16'h3333, 1, 0, 1, 16'h0104, 1, 1, 16'h3333, 1};
        tbl[7] = '{0, 16'h0000, 0, 0, 16'h0000, 0, 1, 1, 16'h0104, 0, 1, 16'h3333, 0};
        tbl[8] = '{0, 16'h0000, 1, 0, 16'h0000, 1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0};

        // Power-on reset state
        #12;
        check("rst.pndng", 32'(pndng), 0);
        check("rst.tx_count", 32'(tx_count), 0);
        check("rst.D_pop", 32'(D_pop), 0);
        check("rst.rx_valid", 32'(rx_valid), 0);
        check("rst.ovf_tx", 32'(ovf_tx), 0);
        release_reset();
        check_all("idle");

        // Vector table
        for (int i = 0; i < 9; i++) begin
            tx_wr = tbl[i].tx_wr; tx_data = tbl[i].tx_data; pop = tbl[i].pop;
            push = tbl[i].push; D_push = tbl[i].d_push; rx_rd = tbl[i].rx_rd; clr_err = tbl[i].clr;
            @(posedge clk);
            #1;
            tx_wr = 0; pop = 0; push = 0; rx_rd = 0; clr_err = 0;
            check($sformatf("vec%0d.tx_count", i), 32'(tx_count), 32'(tbl[i].e_txc));
            check($sformatf("vec%0d.D_pop", i),    32'(D_pop),    32'(tbl[i].e_dpop));
            check($sformatf("vec%0d.ovf_tx", i),   32'(ovf_tx),   32'(tbl[i].e_ovt));
            check($sformatf("vec%0d.rx_count", i), 32'(rx_count), 32'(tbl[i].e_rxc));
            check($sformatf("vec%0d.rx_data", i),  32'(rx_data),  32'(tbl[i].e_rxd));
            check($sformatf("vec%0d.ovf_rx", i),   32'(ovf_rx),   32'(tbl[i].e_ovr));
        end

        // Reset mid-traffic: asynchronous clear without a clock edge
        for (int i = 0; i < 3; i++) cyc("rmt.wr", 1, W'(16'h0A00 + i), 0, 0, '0, 0, 0);
        #2 reset = 1'b0;
        #1;
        check("rmt.pndng", 32'(pndng), 0);
        check("rmt.tx_count", 32'(tx_count), 0);
        check("rmt.D_pop", 32'(D_pop), 0);
        check("rmt.ovf_tx", 32'(ovf_tx), 0);
        check("rmt.ovf_rx", 32'(ovf_rx), 0);
        tx_q.delete(); rx_q.delete(); m_ovt = 0; m_ovr = 0;
        #3;
        release_reset();
        check_all("rmt.after");

        // Fill and drain
        for (int i = 0; i < D; i++) cyc("fill", 1, W'(16'h0101 + i), 0, 0, '0, 0, 0);
        check("fill.tx_full", 32'(tx_full), 1);
        check("fill.tx_count", 32'(tx_count), D);
        for (int i = 0; i < D; i++) begin
            check($sformatf("drain%0d.D_pop", i), 32'(D_pop), 32'(16'h0101 + i));
            cyc("drain", 0, '0, 1, 0, '0, 0, 0);
        end
        check("drain.pndng", 32'(pndng), 0);

        // Overflow while full, then simultaneous write and pop while full
        for (int i = 0; i < D; i++) cyc("fill2", 1, W'(16'h0201 + i), 0, 0, '0, 0, 0);
        cyc("ovf", 1, 16'hDEAD, 0, 0, '0, 0, 0);
        check("ovf.ovf_tx", 32'(ovf_tx), 1);
        check("ovf.tx_count", 32'(tx_count), D);
        cyc("clr", 0, '0, 0, 0, '0, 0, 1);
        cyc("simul", 1, 16'hBEEF, 1, 0, '0, 0, 0);
        check("simul.tx_count", 32'(tx_count), D);
        check("simul.ovf_tx", 32'(ovf_tx), 0);
        seen_dead = 0;
        beef_pos = -1;
        for (int i = 0; i < D; i++) begin
            got = D_pop;
            if (got == 16'hDEAD) seen_dead++;
            if (got == 16'hBEEF) beef_pos = i;
            cyc("drain2", 0, '0, 1, 0, '0, 0, 0);
        end
        check("drain2.dead_seen", 32'(seen_dead), 0);
        check("drain2.beef_pos", 32'(beef_pos), 7);

        // RX wrap-around with occupancy held at 1..3
        max_rx = 0;
        for (int i = 0; i < 20; i++) begin
            int sz;
            sz = rx_q.size();
            if (sz <= 1)       cyc("wrap", 0, '0, 0, 1, W'(16'hA000 + i), 0, 0);
            else if (sz >= 3)  cyc("wrap", 0, '0, 0, 0, '0, 1, 0);
            else if (i % 3 == 0) cyc("wrap", 0, '0, 0, 1, W'(16'hA000 + i), 0, 0);
            else               cyc("wrap", 0, '0, 0, 1, W'(16'hA000 + i), 1, 0);
            if (int'(rx_count) > max_rx) max_rx = int'(rx_count);
        end
        check("wrap.max_rx_le3", 32'(max_rx <= 3), 1);
        for (int i = 0; i < D && rx_q.size() > 0; i++) cyc("rxdrain", 0, '0, 0, 0, '0, 1, 0);

        // Underflow and clear priority
        cyc("unf", 0, '0, 0, 0, '0, 1, 0);
        check("unf.ovf_rx", 32'(ovf_rx), 1);
        cyc("unf.clr_set", 0, '0, 0, 0, '0, 1, 1);
        check("unf.set_wins", 32'(ovf_rx), 1);
        cyc("unf.clr", 0, '0, 0, 0, '0, 0, 1);
        check("unf.cleared", 32'(ovf_rx), 0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            cyc("rand", 1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 2) == 0),
                1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 2) == 0),
                1'($urandom_range(0, 7) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
